axi4lite_write_master: RTL

Requester-side AXI4-Lite write master that turns a simple valid/ready write request into one AXI4-Lite write transaction (AW, W, B channels) and returns the write response to the requester. It sits directly upstream of the AXI4-Lite write slave, driving that slave's AW and W channels and consuming its B channel. It handles one transaction at a time. Misaligned requests are rejected locally without bus activity, matching the slave's alignment rule.

---
 rtl/axi4lite_write_master.sv | 114 +++++++++++
 1 files changed

// File: rtl/axi4lite_write_master.sv
// AXI4-Lite write master: turns a valid/ready write request into one AW/W/B
// transaction and returns the slave response. Misaligned requests get SLVERR locally.
module axi4lite_write_master (
    input  logic        aclk,
    input  logic        areset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [3:0]  req_strb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [1:0]  rsp_resp,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] awaddr,
    output logic [2:0]  awprot,
    output logic        wvalid,
    input  logic        wready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    input  logic        bvalid,
    output logic        bready,
    input  logic [1:0]  bresp
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        WAIT_B = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t state_r;
    logic   aw_done_s;
    logic   w_done_s;

    // A channel counts as done once its valid has dropped or its handshake happens now.
    assign aw_done_s = ~awvalid | awready;
    assign w_done_s  = ~wvalid  | wready;
    assign awprot    = 3'b000;

    // Transaction sequencer; every output it drives is a register.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_r   <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_resp  <= 2'b00;
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
            awaddr    <= 32'h0000_0000;
            wdata     <= 32'h0000_0000;
            wstrb     <= 4'h0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        if (req_addr[1:0] == 2'b00) begin
                            awaddr  <= req_addr;
                            wdata   <= req_data;
                            wstrb   <= req_strb;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            state_r <= SEND;
                        end else begin
                            rsp_resp  <= 2'b10;
                            rsp_valid <= 1'b1;
                            state_r   <= RESP;
                        end
                    end
                end
                SEND: begin
                    if (awvalid && awready) begin
                        awvalid <= 1'b0;
                    end
                    if (wvalid && wready) begin
                        wvalid <= 1'b0;
                    end
                    if (aw_done_s && w_done_s) begin
                        bready  <= 1'b1;
                        state_r <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (bvalid && bready) begin
                        rsp_resp  <= bresp;
                        bready    <= 1'b0;
                        rsp_valid <= 1'b1;
                        state_r   <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_valid && rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    awvalid   <= 1'b0;
                    wvalid    <= 1'b0;
                    bready    <= 1'b0;
                end
            endcase
        end
    end

endmodule
